// File: rtl/matrix_sched_pkg.sv
// Shared types and packing helpers for the matrix-add scheduler.
// A 2x2 complex matrix is NELEM elements of 2*WIDTH bits, imaginary half on top.
package matrix_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int NELEM = 4;

  // Bit offset of element e inside a packed matrix.
  function automatic int elem_lsb(input int e, input int width);
    return e * 2 * width;
  endfunction

  // Bit offset of requester r's matrix inside a per-requester packed bus.
  function automatic int req_lsb(input int r, input int width);
    return r * NELEM * 2 * width;
  endfunction

endpackage

// File: rtl/matrix_add_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above rr_ptr,
// wrapping modulo NREQ; returns a one-hot grant and its index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0] cand [NREQ];

  // cand[k] is the requester examined k positions after the pointer.
  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_cand
    logic [IDW:0] sum;
    assign sum = {1'b0, rr_ptr} + (IDW+1)'(gi);
    assign cand[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                               : sum[IDW-1:0];
  end

  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[cand[k]]) begin
        found           = 1'b1;
        grant[cand[k]]  = 1'b1;
        grant_idx       = cand[k];
      end
    end
  end

endmodule

// File: rtl/matrix_add_sched.sv
// Shares one 2x2 complex matrix-add datapath among NREQ requesters, one
// operation in flight at a time, with a valid/ready response port.
module matrix_add_sched
  import matrix_sched_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int LAT   = 6,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*8*WIDTH-1:0]   req_a,
  input  logic [NREQ*8*WIDTH-1:0]   req_b,
  input  logic [NREQ*5-1:0]         req_m_bit1,
  input  logic [NREQ*5-1:0]         req_m_bit2,
  output logic [8*WIDTH-1:0]        dp_a,
  output logic [8*WIDTH-1:0]        dp_b,
  output logic [4:0]                dp_m_bit1,
  output logic [4:0]                dp_m_bit2,
  output logic                      dp_flag,
  input  logic [8*WIDTH-1:0]        dp_c,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [8*WIDTH-1:0]        rsp_c,
  output logic                      busy,
  output logic [15:0]               op_count
);

  localparam int MW = NELEM * 2 * WIDTH;
  localparam int CW = $clog2(LAT) + 1;

  state_t          state_reg, state_next;
  logic [IDW-1:0]  rr_ptr_reg;
  logic [IDW-1:0]  id_reg;
  logic [CW-1:0]   cnt_reg;
  logic [MW-1:0]   dp_a_reg, dp_b_reg;
  logic [4:0]      dp_m1_reg, dp_m2_reg;
  logic            rsp_valid_reg;
  logic [MW-1:0]   rsp_c_reg;
  logic [IDW-1:0]  rsp_id_reg;
  logic [15:0]     op_count_reg;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  ptr_next;
  logic            any_req;
  logic            grant_fire, capture, rsp_fire;

  logic [MW-1:0]   a_slice  [NREQ];
  logic [MW-1:0]   b_slice  [NREQ];
  logic [4:0]      m1_slice [NREQ];
  logic [4:0]      m2_slice [NREQ];

  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_req
    assign a_slice[gi]  = req_a[req_lsb(gi, WIDTH) +: MW];
    assign b_slice[gi]  = req_b[req_lsb(gi, WIDTH) +: MW];
    assign m1_slice[gi] = req_m_bit1[gi*5 +: 5];
    assign m2_slice[gi] = req_m_bit2[gi*5 +: 5];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign any_req  = |req_valid;
  assign ptr_next = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (cnt_reg == CW'(LAT-1)) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The grant is combinational, so it is masked while reset is held.
  always_comb begin
    req_ready  = '0;
    dp_flag    = 1'b0;
    busy       = 1'b1;
    grant_fire = 1'b0;
    capture    = 1'b0;
    rsp_fire   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        busy       = 1'b0;
        grant_fire = any_req;
        if (!rst) req_ready = grant;
      end
      ISSUE:   dp_flag = 1'b1;
      WAIT:    capture = (cnt_reg == CW'(LAT-1));
      RESP:    rsp_fire = rsp_ready;
      default: busy = 1'b0;
    endcase
  end

  // Operands stay put from the grant edge to the next grant so the datapath
  // may sample them on any cycle of the operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg    <= '0;
      id_reg        <= '0;
      cnt_reg       <= '0;
      dp_a_reg      <= '0;
      dp_b_reg      <= '0;
      dp_m1_reg     <= '0;
      dp_m2_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_c_reg     <= '0;
      rsp_id_reg    <= '0;
      op_count_reg  <= '0;
    end else begin
      if (grant_fire) begin
        dp_a_reg   <= a_slice[grant_idx];
        dp_b_reg   <= b_slice[grant_idx];
        dp_m1_reg  <= m1_slice[grant_idx];
        dp_m2_reg  <= m2_slice[grant_idx];
        id_reg     <= grant_idx;
        rr_ptr_reg <= ptr_next;
      end
      if (state_reg == ISSUE)     cnt_reg <= '0;
      else if (state_reg == WAIT) cnt_reg <= cnt_reg + 1'b1;
      if (capture) begin
        rsp_c_reg     <= dp_c;
        rsp_id_reg    <= id_reg;
        rsp_valid_reg <= 1'b1;
      end else if (rsp_fire) begin
        rsp_valid_reg <= 1'b0;
        op_count_reg  <= op_count_reg + 16'd1;
      end
    end
  end

  assign dp_a      = dp_a_reg;
  assign dp_b      = dp_b_reg;
  assign dp_m_bit1 = dp_m1_reg;
  assign dp_m_bit2 = dp_m2_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_c     = rsp_c_reg;
  assign rsp_id    = rsp_id_reg;
  assign op_count  = op_count_reg;

endmodule

// File: doc/matrix_add_sched.md
Name: matrix_add_sched

Overview:
- Round-robin scheduler that shares one 2x2 complex EFP matrix-add datapath among NREQ requesters.
- Per operation: accepts one request, drives the datapath operand/mode bus, pulses the start flag, and waits a fixed latency. It then captures C and returns it with the requester id on a valid/ready response port.
- Non-overlapped: at most one operation in flight. Sits between the layer-level control FSMs and the matrix-add instance.

Parameters:
- WIDTH, 16: bits per real or imaginary component; one complex element is 2*WIDTH bits, imaginary in the high half.
- NREQ, 4: number of requesters, 2..8.
- LAT, 6: cycles from the flag pulse to a valid datapath result (1 start + 5 compute).
- IDW, $clog2(NREQ): requester id width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  one-hot grant; handshake when valid&ready
- req_a  in  NREQ*8*WIDTH  matrix A per requester; requester i at [i*8W +: 8W]
- req_b  in  NREQ*8*WIDTH  matrix B, same packing as req_a
- req_m_bit1  in  NREQ*5  mantissa-bit config for operand 1, per requester
- req_m_bit2  in  NREQ*5  mantissa-bit config for operand 2, per requester
- dp_a  out  8*WIDTH  operands to datapath; element e=2*row+col at [e*2W +: 2W]
- dp_b  out  8*WIDTH  operands to datapath, same packing as dp_a
- dp_m_bit1  out  5  mode to datapath
- dp_m_bit2  out  5  mode to datapath
- dp_flag  out  1  one-cycle start pulse
- dp_c  in  8*WIDTH  datapath result, same packing as dp_a
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  requester index that owns rsp_c
- rsp_c  out  8*WIDTH  captured result
- busy  out  1  high in every state except IDLE
- op_count  out  16  completed-operation counter; wraps 0xFFFF->0

Behaviour:
- Reset, synchronous, overrides everything:
  - state=IDLE, rr_ptr=0, wait counter=0.
  - All outputs 0: req_ready, dp_*, dp_flag, rsp_*, busy, op_count.
- Reset asserted mid-operation abandons the operation. No response is produced and the next grant starts from requester 0.
- IDLE:
  - If any req_valid, req_ready is asserted combinationally for exactly one requester: the first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - On that edge, latch the granted requester's a, b, m_bit1, m_bit2 into the dp_* registers and its index into id_q. Set rr_ptr=(grant+1) mod NREQ and go to ISSUE.
  - If no req_valid: req_ready=0 and stay in IDLE.
- ISSUE: dp_flag=1 for this cycle only; clear counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - When counter==LAT-1, register dp_c into rsp_c and id_q into rsp_id, set rsp_valid, go to RESP.
  - If dp_flag rises in cycle T, dp_c is sampled at the end of cycle T+LAT and rsp_valid is high from cycle T+LAT+1.
- RESP:
  - rsp_valid, rsp_c and rsp_id are held stable until rsp_ready.
  - On the handshake: rsp_valid=0, op_count+=1, go to IDLE.
  - No grant is issued in the handshake cycle; the earliest next req_ready is the following cycle.
- dp_a, dp_b and dp_m_* stay stable from the latch edge until the next grant, because the datapath may sample them on any cycle of the operation.
- req_ready is 0 in ISSUE, WAIT and RESP.
- A requester that drops req_valid without a handshake is simply not granted; no error is raised.
- Timing: request handshake to rsp_valid is LAT+2 cycles. Minimum period per operation is LAT+3 cycles with rsp_ready tied high.
- A single requester asserting continuously is granted every operation. Fairness guarantee: a waiting requester is granted within NREQ operations.

Decomposition:
- Package matrix_sched_pkg holds: the state enum (IDLE, ISSUE, WAIT, RESP), the element-count constant 4, and the packing helper functions for element and requester slices.
- One sub-module: rr_arbiter (inputs: req vector and rr_ptr; outputs: one-hot grant and index), purely combinational.

Test Plan:
The bench datapath stub returns dp_c = per-16-bit-lane sum dp_a+dp_b, delayed LAT cycles after dp_flag.
- Single request: req 1 with A lanes all 0x0001, B lanes all 0x0002, m_bit1=3, m_bit2=4.
  - Expect req_ready[1] in the handshake cycle and dp_flag exactly 1 cycle later.
  - Expect rsp_valid 8 cycles after the handshake with rsp_id=1, rsp_c lanes all 0x0003, dp_m_bit1=3, op_count=1.
- Fairness: all 4 requesters valid continuously with rsp_ready=1. Expect grant order 0,1,2,3,0 and op_count=5 after 5 responses.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid.
  - Expect rsp_c and rsp_id stable, no req_ready asserted, and one handshake on release.
  - Expect the next grant exactly 1 cycle after release.
- Reset mid-WAIT: assert rst at counter=2.
  - Next cycle expect all outputs 0 and busy=0.
  - The subsequent request from requester 2 is granted, with rr_ptr restarting at 0.
- Wrap: with rr_ptr=3 and requests on 0 and 3, expect 3 granted first, then 0.
- op_count: preload via 65536 operations (or force), then expect the counter to wrap from 0xFFFF to 0x0000.
